aq_djpeg_rgb2axis: RTL

//  Output stage directly downstream of the YCbCr->RGB converter. Accepts cropped-to-image RGB pixels.

---
 rtl/aq_djpeg_pkg.sv | 32 +++
 rtl/aq_djpeg_sfifo.sv | 82 ++++++++
 rtl/aq_djpeg_rgb2axis.sv | 96 +++++++++
 3 files changed

// File: rtl/aq_djpeg_pkg.sv
// Shared types for the JPEG decoder RGB output stage: coordinate/colour widths,
// the FIFO entry layout and the RGB565 packing helper.
// Build option: AQ_DJPEG_RGB565_EN selects 16-bit RGB565 colour storage.
package aq_djpeg_pkg;

    localparam int COORD_W = 16;
    localparam int COLOR_W = 8;

`ifdef AQ_DJPEG_RGB565_EN
    localparam int PIX_W = 16;
`else
    localparam int PIX_W = 3 * COLOR_W;
`endif

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] color_t;

    // One buffered pixel; field order gives {tlast,tuser,y,x,colour}.
    typedef struct packed {
        logic             tlast;
        logic             tuser;
        coord_t           y;
        coord_t           x;
        logic [PIX_W-1:0] colour;
    } fifo_entry_t;

    // Truncate 8-bit components to 5/6/5 bits.
    function automatic logic [15:0] pack_rgb565(input color_t r, input color_t g, input color_t b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/aq_djpeg_sfifo.sv
// Synchronous FIFO with a registered head: the oldest entry is always held in
// a flop so the consumer sees no combinational path from the write side.
module aq_djpeg_sfifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  head_q, head_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Next-state for pointers, occupancy and the head register.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
            // The new head is the incoming word when nothing older remains,
            // otherwise the stored entry at the advanced read pointer.
            if (do_push && (count_q == '0 || (count_q == (ADDR_W+1)'(1) && do_pop)))
                head_d = wdata_i;
            else if (count_d != '0)
                head_d = mem_q[rd_ptr_d];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy is tracked by count_q alone.
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/aq_djpeg_rgb2axis.sv
// RGB output stage: crops MCU padding, tags SOF/last, buffers pixels and
// presents them on an AXI4-Stream master with coordinates.
// Build option: AQ_DJPEG_RGB565_EN packs colour as RGB565 in tdata[15:0].
module aq_djpeg_rgb2axis
    import aq_djpeg_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         DataInit,
    input  logic [15:0]  ImageWidth,
    input  logic [15:0]  ImageHeight,
    input  logic         InEnable,
    output logic         InReady,
    input  logic [15:0]  InPixelX,
    input  logic [15:0]  InPixelY,
    input  logic [7:0]   InR,
    input  logic [7:0]   InG,
    input  logic [7:0]   InB,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [23:0]  m_axis_tdata,
    output logic         m_axis_tuser,
    output logic         m_axis_tlast,
    output logic [15:0]  m_axis_x,
    output logic [15:0]  m_axis_y,
    output logic         FrameDone
);

    fifo_entry_t wr_entry, head;
    logic        fifo_full, fifo_empty;
    logic        ready_q;
    logic        frame_done_q, frame_done_d;
    logic        in_window, push, pop;

    // Hold InReady low until the first clock after reset release.
    assign InReady   = ready_q && !fifo_full;
    assign in_window = (InPixelX < ImageWidth) && (InPixelY < ImageHeight);
    assign push      = InEnable && InReady && in_window && !DataInit;
    assign pop       = m_axis_tvalid && m_axis_tready;

    assign wr_entry.tlast = (InPixelX == ImageWidth - 16'd1) && (InPixelY == ImageHeight - 16'd1);
    assign wr_entry.tuser = (InPixelX == '0) && (InPixelY == '0);
    assign wr_entry.y     = InPixelY;
    assign wr_entry.x     = InPixelX;
`ifdef AQ_DJPEG_RGB565_EN
    assign wr_entry.colour = pack_rgb565(InR, InG, InB);
    assign m_axis_tdata    = {8'h00, head.colour};
`else
    assign wr_entry.colour = {InR, InG, InB};
    assign m_axis_tdata    = head.colour;
`endif

    aq_djpeg_sfifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  ($bits(fifo_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (DataInit),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tuser  = head.tuser;
    assign m_axis_tlast  = head.tlast;
    assign m_axis_x      = head.x;
    assign m_axis_y      = head.y;
    assign FrameDone     = frame_done_q;

    // FrameDone fires the cycle after the tlast beat leaves; a restart clears it.
    always_comb begin
        frame_done_d = pop && head.tlast;
        if (DataInit) frame_done_d = 1'b0;
    end

    // Ready enable and FrameDone registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ready_q      <= 1'b1;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
